// File: rtl/uart_rx.sv
// uart_rx -- UART receiver with 16x oversampling.
//
// Receives LSB-first frames: one start bit, DBIT data bits, no parity, then
// a stop period of SB_TICK oversampling ticks. The start bit is qualified at
// its midpoint (8 ticks in). Each data bit is then sampled 16 ticks after
// the previous sample, which places every sample at the middle of its bit.
//
// Parameters
//   DBIT     data bits per frame (2..16)
//   SB_TICK  stop-period length in s_tick units (16 = 1, 24 = 1.5, 32 = 2 bits)
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   rx            serial line, asynchronous to clk, idles high
//   s_tick        oversampling strobe, 16 per bit period, one clk wide
//   rx_dout       last received word, held until the next frame completes
//   rx_done_tick  one-cycle pulse marking a completed frame
//   frame_err     stop-bit check result for the frame flagged by rx_done_tick
//   dbg_state     current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Output protocol: rx_done_tick is a pure strobe with no backpressure. In the
// cycle it is high, rx_dout and frame_err describe that frame. Both then hold
// their values until the next strobe. A consumer that misses the strobe
// loses the frame.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic [1:0]      dbg_state
);

    // The tick counter must hold both the 16-tick bit period and the stop period.
    localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int SW    = $clog2(S_MAX);
    localparam int NW    = $clog2(DBIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_d;
    logic            err_d;
    logic            done_d;

    // Two-flop synchronizer. Both flops reset high so that releasing reset
    // never produces a false falling edge.
    logic rx_meta, rx_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            s_q          <= '0;
            n_q          <= '0;
            b_q          <= '0;
            rx_dout      <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            n_q          <= n_d;
            b_q          <= b_d;
            rx_dout      <= dout_d;
            rx_done_tick <= done_d;
            frame_err    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = rx_dout;
        err_d   = frame_err;
        done_d  = 1'b0;

        case (state_q)
            // Leaving IDLE does not wait for a tick. The start bit is
            // measured from the first tick seen in START.
            IDLE: begin
                if (!rx_s) begin
                    s_d     = '0;
                    state_d = START;
                end
            end

            START: begin
                if (s_tick) begin
                    if (s_q == SW'(7)) begin
                        if (!rx_s) begin
                            s_d     = '0;
                            n_d     = '0;
                            state_d = DATA;
                        end else begin
                            // The line went high again before the midpoint,
                            // so this was a glitch and no frame is reported.
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            STOP: begin
                if (s_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        dout_d  = b_q;
                        err_d   = ~rx_s;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver with 16x oversampling. Converts the serial `rx` line into parallel `DBIT`-bit words with a one-cycle completion strobe, plus a stop-bit framing check. It sits on the receive side of the serial link, opposite the transmitter, and is timed by the same shared `s_tick` baud-tick generator (16 ticks per bit). Frame format is LSB first: 1 start bit, `DBIT` data bits, no parity, then a stop period of `SB_TICK` ticks.

## Interface
- `DBIT`, 8, number of data bits per frame; legal range 2..16.
- `SB_TICK`, 16, stop-period length in `s_tick` units; 16 = 1 stop bit, 24 = 1.5, 32 = 2.

- `clk`  input  1  system clock; all state changes on its rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `rx`  input  1  serial line; asynchronous to `clk`; idles high.
- `s_tick`  input  1  oversampling strobe, 16 per bit period; one `clk` wide; synchronous to `clk`.
- `rx_dout`  output  `DBIT`  last received word; held until the next frame completes.
- `rx_done_tick`  output  1  one-cycle pulse marking a completed frame.
- `frame_err`  output  1  stop-bit check result for the frame flagged by `rx_done_tick`.

## Operation
- **Synchronizer.** `rx` passes through 2 flip-flops, both reset to 1. The FSM uses only the synchronized signal `rx_s`.
- **Registers.**
  - FSM state: IDLE, START, DATA, STOP.
  - Tick counter `s`: width `$clog2(max(16,SB_TICK))`.
  - Bit counter `n`: width `$clog2(DBIT)`.
  - Shift register `b`: `DBIT` bits.
  - Output registers: `rx_dout`, `rx_done_tick`, `frame_err`.
- **IDLE.** When `rx_s`==0, clear `s` and go to START. An `s_tick` is not required to leave IDLE.
- **START.** On each `s_tick`:
  - If `s`==7 (bit midpoint) and `rx_s`==0: clear `s` and `n`, go to DATA.
  - If `s`==7 and `rx_s`==1: treat as a false start and return to IDLE. No strobe.
  - Otherwise increment `s`.
- **DATA.** On each `s_tick`:
  - If `s`==15: clear `s` and shift right with `b` = {`rx_s`, `b[DBIT-1:1]`}. If `n`==`DBIT-1`, clear `s` and go to STOP; otherwise increment `n`.
  - Otherwise increment `s`.
  - Samples therefore land at the middle of each data bit.
- **STOP.** On each `s_tick`:
  - If `s`==`SB_TICK-1`: register `rx_dout`=`b`, `frame_err`=~`rx_s`, and `rx_done_tick`=1, then go to IDLE.
  - Otherwise increment `s`.
- **Outside a frame.** `rx_dout` and `frame_err` do not change. A frame with `frame_err`=1 still updates `rx_dout`.
- **No `s_tick`.** Cycles without `s_tick` change nothing except the synchronizer and the IDLE→START transition.
- **Illegal state encodings.** Go to IDLE on the next clock.

## Timing
- **Reset values** (asynchronous, immediate): state IDLE, `s`=0, `n`=0, `b`=0, `rx_dout`=0, `rx_done_tick`=0, `frame_err`=0, synchronizer flops=1.
- **Reset mid-frame.** Aborts the frame with no `rx_done_tick`. After release, the block waits for a new falling edge on `rx_s`.
- **Start detection latency.** 2 `clk` cycles from the falling edge on `rx` to `rx_s`, plus 1 cycle to enter START.
- **`rx_done_tick`.**
  - High for exactly 1 `clk`: the cycle after the edge that consumed the final stop `s_tick`.
  - `rx_dout` and `frame_err` are valid in that same cycle and stay stable afterwards.
- **Frame length.** Completion occurs 8 + 16·`DBIT` + `SB_TICK` ticks after START entry (152 ticks for defaults).
- **Back-to-back frames.** The FSM is in IDLE in the `rx_done_tick` cycle. A start edge already present on `rx_s` moves it to START on the next clock. No idle gap is required beyond the stop period.
- **Break condition.** With `rx` held low, each frame ends with `frame_err`=1 and `rx_dout`=0, then detection restarts immediately. Repeated error frames are the required behaviour.
- **Glitches.** A low pulse shorter than 8 ticks on `rx_s` is rejected at the START midpoint check.

## Test plan
- **Single frame.** Send 0xA5 with defaults (16 ticks/bit, 1 stop) → exactly one `rx_done_tick`, `rx_dout`=0xA5, `frame_err`=0, 152±1 ticks after START entry.
- **False start.** Drive `rx` low for 4 ticks, then high → no `rx_done_tick`, FSM back in IDLE, `rx_dout` unchanged.
- **Framing error.** Send 0x3C with the stop bit held low → `rx_done_tick`=1, `rx_dout`=0x3C, `frame_err`=1. The next valid frame 0x55 → `frame_err`=0.
- **Back-to-back.** Send 0x00, 0xFF, 0x81 with zero idle, `SB_TICK`=32 → three strobes with `rx_dout` 0x00, 0xFF, 0x81 in order, none lost.
- **Reset mid-frame.** Assert `reset_n`=0 during data bit 4 of 0x96 → all outputs 0 immediately. Release while `rx` is high, then send 0x96 → single strobe, `rx_dout`=0x96.
- **Width and tick skew.** `DBIT`=7, `s_tick` every 3 `clk`, send 0x5A → `rx_dout`=0x5A, `frame_err`=0, `rx_done_tick` one `clk` wide.
